// File: rtl/ntsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntsc_pkg
// Purpose  : Shared constants and types for the NTSC pattern sequencer:
//            3-3-2 pixel width, black level, sequencer state encoding and
//            the conventional source slot assignments.
// Revision : 1.0 - initial release
// ============================================================================
package ntsc_pkg;

  localparam int          RGB332_W = 8;
  localparam logic [7:0]  BLACK    = 8'h00;

  // Sequencer FSM encoding: RUN accepts host commands, PEND holds one
  // accepted command until the next frame boundary.
  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_PEND = 1'b1
  } seq_state_t;

  // Conventional source slots on the packed src_rgb bus.
  localparam logic [1:0] SRC_PALETTE = 2'd0;
  localparam logic [1:0] SRC_BARS    = 2'd1;
  localparam logic [1:0] SRC_FB      = 2'd2;
  localparam logic [1:0] SRC_TEST    = 2'd3;

endpackage : ntsc_pkg
`default_nettype wire

// File: rtl/ntsc_pattern_sequencer_scroll.sv
`default_nettype none
// ============================================================================
// Module   : scroll_offset_gen
// Purpose  : Ping-pong 9-bit vertical offset for the palette generator.
//            Steps once per frame while enabled: counts up to SCROLL_MAX,
//            holds there for one frame while turning round, counts down to
//            0, holds there for one frame, and repeats.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            clear           - synchronous clear to 0 / direction up
//                              (takes priority over stepping)
//            enable          - scrolling active
//            step            - frame boundary strobe
//            y_offset        - current offset
// Revision : 1.0 - initial release
// ============================================================================
module scroll_offset_gen #(
  parameter logic [8:0] SCROLL_MAX = 9'd112
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       step,
  output logic [8:0] y_offset
);

  logic [8:0] r_offset;
  logic       r_dir_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset   <= 9'd0;
      r_dir_down <= 1'b0;
    end else if (clear) begin
      r_offset   <= 9'd0;
      r_dir_down <= 1'b0;
    end else if (enable && step) begin
      // At either end the value is held for the turning frame; only the
      // direction flips.
      if (!r_dir_down) begin
        if (r_offset == SCROLL_MAX) begin
          r_dir_down <= 1'b1;
        end else begin
          r_offset <= r_offset + 9'd1;
        end
      end else begin
        if (r_offset == 9'd0) begin
          r_dir_down <= 1'b0;
        end else begin
          r_offset <= r_offset - 9'd1;
        end
      end
    end
  end

  assign y_offset = r_offset;

endmodule : scroll_offset_gen
`default_nettype wire

// File: rtl/ntsc_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntsc_pattern_sequencer
// Purpose  : Frame-synchronous selector sharing the RGB 3-3-2 output path
//            between up to four pattern sources. The displayed source only
//            changes on a frame boundary, either from a host command or
//            from the auto-cycle dwell timer. Also drives the palette's
//            bouncing vertical start offset.
// Ports    : clk, rst_n            - pixel clock, async active-low reset
//            frame_start           - 1-cycle pulse at start of vblank
//            active_video          - active pixel region
//            src_rgb               - packed sources, slot i at [8i+7:8i]
//            cmd_valid/cmd_ready   - host command handshake
//            cmd_src/auto/scroll   - command payload
//            rgb_out               - selected pixel, 1 clk latency
//            cur_src               - source currently displayed
//            y_offset              - palette vertical start offset
//            switch_pulse          - 1-cycle pulse when cur_src changes
// Revision : 1.0 - initial release
// ============================================================================
module ntsc_pattern_sequencer
  import ntsc_pkg::*;
#(
  parameter int         NUM_SRC      = 4,
  parameter int         DWELL_FRAMES = 60,
  parameter logic [8:0] SCROLL_MAX   = 9'd112
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 active_video,
  input  logic [NUM_SRC*8-1:0] src_rgb,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_src,
  input  logic                 cmd_auto,
  input  logic                 cmd_scroll,
  output logic [7:0]           rgb_out,
  output logic [1:0]           cur_src,
  output logic [8:0]           y_offset,
  output logic                 switch_pulse
);

  localparam logic [15:0] c_dwell_last = 16'(DWELL_FRAMES - 1);
  localparam logic [1:0]  c_last_src   = 2'(NUM_SRC - 1);
  localparam logic [2:0]  c_num_src    = 3'(NUM_SRC);

  // --------------------------------------------------------------------------
  // Source unpacking. Slots beyond NUM_SRC read as black so the select can
  // always use the full 2-bit index without width games.
  // --------------------------------------------------------------------------
  logic [RGB332_W-1:0] w_src_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    if (gi < NUM_SRC) begin : g_used
      assign w_src_arr[gi] = src_rgb[gi*8 +: 8];
    end else begin : g_unused
      assign w_src_arr[gi] = BLACK;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seq_state_t  r_state;
  logic        r_cmd_ready;
  logic [1:0]  r_pend_src;
  logic        r_pend_auto;
  logic        r_pend_scroll;
  logic        r_auto;
  logic        r_scroll;
  logic [15:0] r_dwell;
  logic [1:0]  r_cur_src;
  logic        r_switch;
  logic [7:0]  r_rgb;

  // --------------------------------------------------------------------------
  // Next source / dwell decision for the coming frame boundary
  // --------------------------------------------------------------------------
  logic        w_apply;
  logic [1:0]  w_pend_src_ok;
  logic [1:0]  w_src_inc;
  logic [1:0]  w_next_src;
  logic [15:0] w_next_dwell;

  always_comb begin
    w_apply       = (r_state == S_PEND) && frame_start;
    // An index outside the populated slots falls back to the palette.
    w_pend_src_ok = ({1'b0, r_pend_src} < c_num_src) ? r_pend_src : SRC_PALETTE;
    w_src_inc     = (r_cur_src == c_last_src) ? 2'd0 : r_cur_src + 2'd1;
    w_next_src    = r_cur_src;
    w_next_dwell  = r_dwell;
    if (frame_start) begin
      if (w_apply) begin
        // A command landing on the same frame as an auto advance wins and
        // restarts the dwell period.
        w_next_src   = w_pend_src_ok;
        w_next_dwell = 16'd0;
      end else if (r_auto) begin
        // Compare before incrementing so the advance lands on the
        // DWELL_FRAMES-th boundary (every boundary when DWELL_FRAMES=1).
        if (r_dwell == c_dwell_last) begin
          w_next_dwell = 16'd0;
          w_next_src   = w_src_inc;
        end else begin
          w_next_dwell = r_dwell + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command FSM, source select, and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_cmd_ready   <= 1'b1;
      r_pend_src    <= 2'd0;
      r_pend_auto   <= 1'b0;
      r_pend_scroll <= 1'b0;
      r_auto        <= 1'b0;
      r_scroll      <= 1'b0;
      r_dwell       <= 16'd0;
      r_cur_src     <= 2'd0;
      r_switch      <= 1'b0;
      r_rgb         <= BLACK;
    end else begin
      r_rgb     <= active_video ? w_src_arr[r_cur_src] : BLACK;
      r_cur_src <= w_next_src;
      r_dwell   <= w_next_dwell;
      // w_next_src can only differ from r_cur_src on a frame boundary.
      r_switch  <= (w_next_src != r_cur_src);

      case (r_state)
        S_RUN: begin
          // A command arriving alongside frame_start is only latched here;
          // it waits for the following boundary.
          if (cmd_valid && r_cmd_ready) begin
            r_pend_src    <= cmd_src;
            r_pend_auto   <= cmd_auto;
            r_pend_scroll <= cmd_scroll;
            r_cmd_ready   <= 1'b0;
            r_state       <= S_PEND;
          end
        end
        S_PEND: begin
          if (frame_start) begin
            r_auto      <= r_pend_auto;
            r_scroll    <= r_pend_scroll;
            r_cmd_ready <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Palette scroll offset. A command with scroll off snaps the offset home
  // on the boundary where it is applied.
  // --------------------------------------------------------------------------
  logic w_scroll_clear;
  assign w_scroll_clear = w_apply && !r_pend_scroll;

  scroll_offset_gen #(
    .SCROLL_MAX (SCROLL_MAX)
  ) u_scroll (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_scroll_clear),
    .enable   (r_scroll),
    .step     (frame_start),
    .y_offset (y_offset)
  );

  assign cmd_ready    = r_cmd_ready;
  assign rgb_out      = r_rgb;
  assign cur_src      = r_cur_src;
  assign switch_pulse = r_switch;

endmodule : ntsc_pattern_sequencer
`default_nettype wire

// File: tb/tb_ntsc_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntsc_pattern_sequencer
// Purpose  : Directed self-checking bench for ntsc_pattern_sequencer with
//            DWELL_FRAMES=3, NUM_SRC=4, SCROLL_MAX=112.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntsc_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        active_video;
  logic [31:0] src_rgb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_src;
  logic        cmd_auto;
  logic        cmd_scroll;
  logic [7:0]  rgb_out;
  logic [1:0]  cur_src;
  logic [8:0]  y_offset;
  logic        switch_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ntsc_pattern_sequencer #(
    .NUM_SRC      (4),
    .DWELL_FRAMES (3),
    .SCROLL_MAX   (9'd112)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .active_video (active_video),
    .src_rgb      (src_rgb),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src      (cmd_src),
    .cmd_auto     (cmd_auto),
    .cmd_scroll   (cmd_scroll),
    .rgb_out      (rgb_out),
    .cur_src      (cur_src),
    .y_offset     (y_offset),
    .switch_pulse (switch_pulse)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] s, input logic a, input logic sc);
    cmd_valid  = 1'b1;
    cmd_src    = s;
    cmd_auto   = a;
    cmd_scroll = sc;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    active_video = 1'b0;
    src_rgb      = 32'h0;
    cmd_valid    = 1'b0;
    cmd_src      = 2'd0;
    cmd_auto     = 1'b0;
    cmd_scroll   = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("rst_rgb_out", 16'(rgb_out), 16'h00);
    chk("rst_cur_src", 16'(cur_src), 16'd0);
    chk("rst_y_offset", 16'(y_offset), 16'd0);
    chk("rst_switch", 16'(switch_pulse), 16'd0);
    rst_n = 1'b1;
    tick();

    // Pixel path, 1 clk latency
    src_rgb      = {8'hE0, 8'h1C, 8'h03, 8'hFF};
    active_video = 1'b1;
    tick();
    chk("pix_src0", 16'(rgb_out), 16'hFF);
    active_video = 1'b0;
    tick();
    chk("pix_blank", 16'(rgb_out), 16'h00);
    active_video = 1'b1;
    tick();

    // Command src=2 mid-frame, applied at next frame_start
    send_cmd(2'd2, 1'b0, 1'b0);
    chk("cmd_ready_drop", 16'(cmd_ready), 16'd0);
    tick();
    chk("cmd_pend_src", 16'(cur_src), 16'd0);
    frame();
    chk("cmd_apply_src", 16'(cur_src), 16'd2);
    chk("cmd_apply_pulse", 16'(switch_pulse), 16'd1);
    chk("cmd_ready_back", 16'(cmd_ready), 16'd1);
    tick();
    chk("cmd_rgb_1c", 16'(rgb_out), 16'h1C);
    chk("cmd_pulse_end", 16'(switch_pulse), 16'd0);

    // Same index again: no pulse
    send_cmd(2'd2, 1'b0, 1'b0);
    tick();
    frame();
    chk("same_src", 16'(cur_src), 16'd2);
    chk("same_no_pulse", 16'(switch_pulse), 16'd0);

    // Auto mode, DWELL_FRAMES=3: start at source 0
    send_cmd(2'd0, 1'b1, 1'b0);
    frame();
    chk("auto_start_src", 16'(cur_src), 16'd0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      frame();
      chk($sformatf("auto_src_f%0d", k), 16'(cur_src), 16'((k / 3) % 4));
      chk($sformatf("auto_pulse_f%0d", k), 16'(switch_pulse), 16'(k % 3 == 0));
      tick();
    end

    // Command coinciding with the 3rd dwell frame wins; dwell restarts
    frame(); tick();
    frame(); tick();
    chk("auto_cmd_pre", 16'(cur_src), 16'd0);
    send_cmd(2'd3, 1'b1, 1'b0);
    frame();
    chk("auto_cmd_win", 16'(cur_src), 16'd3);
    tick();
    frame(); tick();
    chk("auto_cmd_hold1", 16'(cur_src), 16'd3);
    frame(); tick();
    chk("auto_cmd_hold2", 16'(cur_src), 16'd3);
    frame(); tick();
    chk("auto_cmd_next", 16'(cur_src), 16'd0);

    // Scroll mode: 230 frames of ping-pong offset
    send_cmd(2'd0, 1'b0, 1'b1);
    frame();
    chk("scroll_start", 16'(y_offset), 16'd0);
    for (int k = 1; k <= 230; k++) begin
      frame();
      case (k)
        1:   chk("scroll_f1",   16'(y_offset), 16'd1);
        112: chk("scroll_f112", 16'(y_offset), 16'd112);
        113: chk("scroll_f113", 16'(y_offset), 16'd112);
        114: chk("scroll_f114", 16'(y_offset), 16'd111);
        225: chk("scroll_f225", 16'(y_offset), 16'd0);
        226: chk("scroll_f226", 16'(y_offset), 16'd0);
        227: chk("scroll_f227", 16'(y_offset), 16'd1);
        230: chk("scroll_f230", 16'(y_offset), 16'd4);
        default: ;
      endcase
    end

    // Scroll off via command forces offset home on apply
    send_cmd(2'd0, 1'b0, 1'b0);
    chk("scroll_pend_hold", 16'(y_offset), 16'd4);
    frame();
    chk("scroll_clear", 16'(y_offset), 16'd0);
    frame();
    chk("scroll_stays0", 16'(y_offset), 16'd0);

    // Command coinciding with frame_start waits a full frame
    frame_start = 1'b1;
    send_cmd(2'd1, 1'b0, 1'b0);
    frame_start = 1'b0;
    chk("coinc_not_yet", 16'(cur_src), 16'd0);
    chk("coinc_ready", 16'(cmd_ready), 16'd0);
    tick();
    frame();
    chk("coinc_apply", 16'(cur_src), 16'd1);
    chk("coinc_pulse", 16'(switch_pulse), 16'd1);
    tick();

    // Reset with a command pending: command discarded
    send_cmd(2'd2, 1'b0, 1'b0);
    chk("rstpend_ready0", 16'(cmd_ready), 16'd0);
    rst_n = 1'b0;
    tick();
    chk("rstpend_ready", 16'(cmd_ready), 16'd1);
    chk("rstpend_src", 16'(cur_src), 16'd0);
    rst_n = 1'b1;
    tick();
    frame();
    chk("rstpend_after_src", 16'(cur_src), 16'd0);
    chk("rstpend_no_pulse", 16'(switch_pulse), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ntsc_pattern_sequencer
`default_nettype wire
